rv32i_ifetch: RTL

Instruction fetch stage sitting directly downstream of the program counter stage. Accepts fetch addresses over a valid/ready handshake and issues in-order requests on the instruction-memory bus. Collects responses in an allocate-at-request / fill-at-response buffer and presents {instruction, PC} pairs in program order to decode over a valid/ready handshake. Supports single-cycle flush on redirect (branch/jump), with discard of in-flight responses.

---
 rtl/rv32i_ifetch_if.sv | 37 +++
 rtl/rv32i_ifetch.sv | 111 +++++++++++
 2 files changed

// File: rtl/rv32i_ifetch_if.sv
// Bundle of the PC-stage, instruction-memory and decode handshakes seen by rv32i_ifetch.
// O_INST_MISALIGN exists only when RV32I_IFETCH_MISALIGN_EN is defined.
interface rv32i_ifetch_if;
    logic [31:0] I_PC;
    logic        I_PC_VLD;
    logic        O_PC_RDY;
    logic        I_FLUSH;
    logic        O_IMEM_REQ;
    logic [31:0] O_IMEM_ADDR;
    logic        I_IMEM_GNT;
    logic        I_IMEM_RVLD;
    logic [31:0] I_IMEM_RDATA;
    logic        O_INST_VLD;
    logic [31:0] O_INST;
    logic [31:0] O_INST_PC;
    logic        I_INST_RDY;
`ifdef RV32I_IFETCH_MISALIGN_EN
    logic        O_INST_MISALIGN;
`endif

    // master is the fetch unit; slave is everything around it (PC stage, memory, decode)
    modport master (
        input  I_PC, I_PC_VLD, I_FLUSH, I_IMEM_GNT, I_IMEM_RVLD, I_IMEM_RDATA, I_INST_RDY,
        output O_PC_RDY, O_IMEM_REQ, O_IMEM_ADDR, O_INST_VLD, O_INST, O_INST_PC
`ifdef RV32I_IFETCH_MISALIGN_EN
        , output O_INST_MISALIGN
`endif
    );

    modport slave (
        output I_PC, I_PC_VLD, I_FLUSH, I_IMEM_GNT, I_IMEM_RVLD, I_IMEM_RDATA, I_INST_RDY,
        input  O_PC_RDY, O_IMEM_REQ, O_IMEM_ADDR, O_INST_VLD, O_INST, O_INST_PC
`ifdef RV32I_IFETCH_MISALIGN_EN
        , input O_INST_MISALIGN
`endif
    );
endinterface

// File: rtl/rv32i_ifetch.sv
// RV32I fetch stage: in-order imem requests, allocate-at-request/fill-at-response buffer, flush with drop.
// Optional RV32I_IFETCH_MISALIGN_EN turns misaligned PCs into NOP entries flagged misaligned.
module rv32i_ifetch #(
    parameter  int FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    rv32i_ifetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [PTR_W-1:0]      alloc_ptr, fill_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, pend_cnt, drop_cnt;
    logic [31:0]           ent_pc   [FIFO_DEPTH];
    logic [31:0]           ent_inst [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_filled;
`ifdef RV32I_IFETCH_MISALIGN_EN
    logic [FIFO_DEPTH-1:0] ent_mis;
`endif

    logic space, pc_misaligned, imem_req, grant, mis_accept, alloc;
    logic rsp_take, rsp_fill, inst_vld, pop;

    // A pop in the same cycle does not free space: no pass-through from pop to request.
    always_comb begin
        space         = count < CNT_W'(FIFO_DEPTH);
`ifdef RV32I_IFETCH_MISALIGN_EN
        pc_misaligned = bus.I_PC[1:0] != 2'b00;
        mis_accept    = bus.I_PC_VLD && pc_misaligned && space && !bus.I_FLUSH &&
                        drop_cnt == '0 && pend_cnt == '0;
`else
        pc_misaligned = 1'b0;
        mis_accept    = 1'b0;
`endif
        imem_req = bus.I_PC_VLD && space && !bus.I_FLUSH && !pc_misaligned;
        grant    = imem_req && bus.I_IMEM_GNT;
        alloc    = grant || mis_accept;
        // Any response matched to a real request or pending drop; orphans are ignored.
        rsp_take = bus.I_IMEM_RVLD && (drop_cnt != '0 || pend_cnt != '0);
        rsp_fill = rsp_take && !bus.I_FLUSH && drop_cnt == '0;
        inst_vld = count != '0 && ent_filled[rd_ptr];
        pop      = inst_vld && bus.I_INST_RDY;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_cnt   <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
`ifdef RV32I_IFETCH_MISALIGN_EN
            ent_mis    <= '0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_inst[i] <= '0;
            end
        end else if (bus.I_FLUSH) begin
            // Every unfilled entry still has a response coming; the one arriving now is pre-flush.
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_cnt   <= '0;
            ent_filled <= '0;
            drop_cnt   <= drop_cnt + pend_cnt - CNT_W'(rsp_take);
        end else begin
            if (alloc) begin
                ent_pc[alloc_ptr]     <= bus.I_PC;
                ent_filled[alloc_ptr] <= mis_accept;
`ifdef RV32I_IFETCH_MISALIGN_EN
                ent_mis[alloc_ptr]    <= mis_accept;
                if (mis_accept)
                    ent_inst[alloc_ptr] <= NOP;
`endif
                alloc_ptr <= alloc_ptr + PTR_W'(1);
            end
            if (rsp_fill) begin
                ent_inst[fill_ptr]   <= bus.I_IMEM_RDATA;
                ent_filled[fill_ptr] <= 1'b1;
            end
            if (rsp_fill || mis_accept)
                fill_ptr <= fill_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count + CNT_W'(alloc) - CNT_W'(pop);
            pend_cnt <= pend_cnt + CNT_W'(grant) - CNT_W'(rsp_fill);
            if (bus.I_IMEM_RVLD && drop_cnt != '0)
                drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    assign bus.O_IMEM_REQ  = imem_req;
    assign bus.O_IMEM_ADDR = {bus.I_PC[31:2], 2'b00};
    assign bus.O_PC_RDY    = alloc;
    assign bus.O_INST_VLD  = inst_vld;
    assign bus.O_INST      = ent_inst[rd_ptr];
    assign bus.O_INST_PC   = ent_pc[rd_ptr];
`ifdef RV32I_IFETCH_MISALIGN_EN
    assign bus.O_INST_MISALIGN = count != '0 && ent_mis[rd_ptr];
`endif

    // A response with nothing outstanding and nothing to drop is a memory protocol error.
    a_no_orphan_rsp: assert property (@(posedge I_CLK) disable iff (!I_RST_N)
        !(bus.I_IMEM_RVLD && drop_cnt == '0 && pend_cnt == '0));
endmodule
